// File: rtl/coin_change_dispenser.sv
// coin_change_dispenser
//   Takes a refund amount from the vending controller and pays it out greedily
//   in 1000/500/100 coins, one registered one-hot pulse per coin with a
//   GAP_CYCLES idle spacing between pulses. Whatever cannot be paid is reported
//   on o_shortfall when the request completes.
//
//   Optional feature macro: HOPPER_LIMIT_EN
//     defined   : per-denomination hopper counters are tracked and enforced,
//                 refilled by i_refill_coin, and reported on o_hopper_empty.
//     undefined : hoppers are infinite; i_refill_coin is ignored and
//                 o_hopper_empty is tied to 0.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   i_req_valid      refund request present (held until o_req_ready)
//   o_req_ready      high only in IDLE
//   i_req_amount     refund amount, sampled on valid && ready
//   i_refill_coin    one-hot refill pulse ([0]=100, [1]=500, [2]=1000)
//   o_return_coin    one-hot coin pulse, same bit order
//   o_busy           request in progress
//   o_done           one-cycle completion pulse
//   o_shortfall      unpaid remainder of the last request
//   o_hopper_empty   per-denomination empty flags
module coin_change_dispenser #(
  parameter int AMT_W      = 16,
  parameter int CNT_W      = 8,
  parameter int INIT_100   = 50,
  parameter int INIT_500   = 20,
  parameter int INIT_1000  = 10,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [AMT_W-1:0] i_req_amount,
  input  logic [2:0]       i_refill_coin,
  output logic [2:0]       o_return_coin,
  output logic             o_busy,
  output logic             o_done,
  output logic [AMT_W-1:0] o_shortfall,
  output logic [2:0]       o_hopper_empty
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_EMIT, S_GAP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [3:0]       gap_q, gap_d;
  logic [2:0]       coin_q, coin_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] sf_q, sf_d;
  logic [2:0]       empty_q, empty_d;
  logic [2:0]       avail;
  logic [2:0]       sel;

  function automatic logic [AMT_W-1:0] coin_value(input logic [2:0] c);
    case (c)
      3'b100:  coin_value = AMT_W'(1000);
      3'b010:  coin_value = AMT_W'(500);
      3'b001:  coin_value = AMT_W'(100);
      default: coin_value = '0;
    endcase
  endfunction

`ifdef HOPPER_LIMIT_EN
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;

  // Refill and dispense of the same hopper in one cycle cancel out; refills
  // saturate at the counter maximum. A hopper is only ever decremented after
  // SELECT saw it non-zero, so no underflow guard is needed.
  always_comb begin
    cnt_d   = cnt_q;
    empty_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (i_refill_coin[i] && !(state_q == S_EMIT && coin_q[i])) begin
        if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!i_refill_coin[i] && state_q == S_EMIT && coin_q[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
      empty_d[i] = (cnt_d[i] == '0);
      avail[i]   = (cnt_q[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q[0] <= CNT_W'(INIT_100);
      cnt_q[1] <= CNT_W'(INIT_500);
      cnt_q[2] <= CNT_W'(INIT_1000);
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_refill;
  assign unused_refill = ^i_refill_coin;

  always_comb begin
    avail   = 3'b111;
    empty_d = 3'b000;
  end
`endif

  // Greedy pick: largest coin that fits the remainder and is in stock.
  always_comb begin
    sel = 3'b000;
    if (rem_q >= AMT_W'(1000) && avail[2])     sel = 3'b100;
    else if (rem_q >= AMT_W'(500) && avail[1]) sel = 3'b010;
    else if (rem_q >= AMT_W'(100) && avail[0]) sel = 3'b001;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      coin_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sf_q    <= '0;
      empty_q <= 3'b000;
`ifdef HOPPER_LIMIT_EN
      empty_q <= {INIT_1000 == 0, INIT_500 == 0, INIT_100 == 0};
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      coin_q  <= coin_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sf_q    <= sf_d;
      empty_q <= empty_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (i_req_valid && ready_q) begin
          rem_d   = i_req_amount;
          state_d = S_SELECT;
        end
      end
      S_SELECT: state_d = (sel != 3'b000) ? S_EMIT : S_DONE;
      S_EMIT: begin
        rem_d   = rem_q - coin_value(coin_q);
        gap_d   = 4'(GAP_CYCLES - 1);
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_SELECT;
        else             gap_d   = gap_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: every output is registered, so it is derived from the
  // state being entered rather than the current one.
  always_comb begin
    coin_d  = (state_q == S_SELECT) ? sel : 3'b000;
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_SELECT) || (state_d == S_EMIT) || (state_d == S_GAP);
    done_d  = (state_d == S_DONE);
    sf_d    = (state_q == S_SELECT && state_d == S_DONE) ? rem_q : sf_q;
  end

  assign o_req_ready    = ready_q;
  assign o_return_coin  = coin_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_shortfall    = sf_q;
  assign o_hopper_empty = empty_q;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Directed bench for coin_change_dispenser. Small hoppers (1000:3, 500:2,
// 100:6) and GAP_CYCLES=2 so that drain, shortfall and refill cases come
// from a short request sequence. Expectations depend on HOPPER_LIMIT_EN.
module tb_coin_change_dispenser;
  localparam int AMT_W = 16;
  localparam int GAP   = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_req_valid;
  logic             o_req_ready;
  logic [AMT_W-1:0] i_req_amount;
  logic [2:0]       i_refill_coin;
  logic [2:0]       o_return_coin;
  logic             o_busy;
  logic             o_done;
  logic [AMT_W-1:0] o_shortfall;
  logic [2:0]       o_hopper_empty;

  int vectors     = 0;
  int miscompares = 0;
  int exp_coins[$];
  int npulse;
  int late_pulses;

  always #5 clk = ~clk;

  coin_change_dispenser #(
    .AMT_W(AMT_W), .CNT_W(8), .INIT_100(6), .INIT_500(2), .INIT_1000(3),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset(reset), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_amount(i_req_amount), .i_refill_coin(i_refill_coin),
    .o_return_coin(o_return_coin), .o_busy(o_busy), .o_done(o_done),
    .o_shortfall(o_shortfall), .o_hopper_empty(o_hopper_empty)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Issues one request from IDLE and follows it to o_done, checking each
  // pulse value and cycle (cycle 1 = first cycle after acceptance).
  task automatic run_req(input string tag, input int amt, input int rf_cyc,
                         input logic [2:0] rf_val, input int exp_sf);
    int  np;
    bit  seen;
    np   = 0;
    seen = 0;
    @(negedge clk);
    chk({tag, " ready_before"}, o_req_ready, 1);
    i_req_valid  = 1'b1;
    i_req_amount = AMT_W'(amt);
    for (int k = 1; k <= 150 && !seen; k++) begin
      @(negedge clk);
      i_req_valid   = 1'b0;
      i_refill_coin = (k == rf_cyc) ? rf_val : 3'b000;
      if (k == 1) begin
        chk({tag, " busy_c1"}, o_busy, 1);
        chk({tag, " ready_c1"}, o_req_ready, 0);
      end
      if (o_return_coin != 3'b000) begin
        if (np < exp_coins.size()) begin
          chk({tag, " pulse_val"}, o_return_coin, exp_coins[np]);
          chk({tag, " pulse_cyc"}, k, 2 + np * (GAP + 2));
        end else begin
          chk({tag, " extra_pulse"}, o_return_coin, 0);
        end
        np++;
      end
      if (o_done) begin
        seen = 1;
        chk({tag, " done_cyc"}, k, 2 + exp_coins.size() * (GAP + 2));
        chk({tag, " n_pulses"}, np, exp_coins.size());
        chk({tag, " shortfall"}, o_shortfall, exp_sf);
        chk({tag, " busy_done"}, o_busy, 0);
      end
    end
    i_refill_coin = 3'b000;
    chk({tag, " done_seen"}, seen, 1);
    @(negedge clk);
    chk({tag, " ready_after"}, o_req_ready, 1);
    chk({tag, " done_1cyc"}, o_done, 0);
  endtask

  initial begin
    reset         = 1'b1;
    i_req_valid   = 1'b0;
    i_req_amount  = '0;
    i_refill_coin = 3'b000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst ready", o_req_ready, 1);
    chk("rst coin", o_return_coin, 0);
    chk("rst busy", o_busy, 0);
    chk("rst done", o_done, 0);
    chk("rst shortfall", o_shortfall, 0);
    chk("rst empty", o_hopper_empty, 3'b000);

    exp_coins = '{4, 4, 2, 1, 1, 1};
    run_req("r2800", 2800, 0, 3'b000, 0);
    chk("r2800 empty", o_hopper_empty, 3'b000);

    exp_coins = '{1, 1};
    run_req("r250", 250, 0, 3'b000, 50);

    exp_coins = {};
    run_req("r0", 0, 0, 3'b000, 0);

`ifdef HOPPER_LIMIT_EN
    exp_coins = '{4, 2, 1};
    run_req("r4800", 4800, 0, 3'b000, 3200);
    chk("r4800 empty", o_hopper_empty, 3'b111);
`else
    exp_coins = '{4, 4, 4, 4, 2, 1, 1, 1};
    run_req("r4800", 4800, 0, 3'b000, 0);
    chk("r4800 empty", o_hopper_empty, 3'b000);
`endif

    // Idle refill of one 1000 coin.
    @(negedge clk);
    i_refill_coin = 3'b100;
    @(negedge clk);
    i_refill_coin = 3'b000;
    @(negedge clk);
`ifdef HOPPER_LIMIT_EN
    chk("refill empty", o_hopper_empty, 3'b011);
`else
    chk("refill empty", o_hopper_empty, 3'b000);
`endif

    // 500 refill lands in the first GAP (cycle 3) and is paid at cycle 6.
    exp_coins = '{4, 2};
    run_req("r1500", 1500, 3, 3'b010, 0);
`ifdef HOPPER_LIMIT_EN
    chk("r1500 empty", o_hopper_empty, 3'b111);
`else
    chk("r1500 empty", o_hopper_empty, 3'b000);
`endif

    // Fresh reset restores the hoppers.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2 empty", o_hopper_empty, 3'b000);
    chk("rst2 shortfall", o_shortfall, 0);

    // Reset during the 3rd pulse (500 at cycle 10) aborts the request.
    @(negedge clk);
    i_req_valid  = 1'b1;
    i_req_amount = AMT_W'(2800);
    npulse = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      i_req_valid = 1'b0;
      if (o_return_coin != 3'b000) npulse++;
    end
    chk("abort 3rd pulse", o_return_coin, 3'b010);
    chk("abort n_before", npulse, 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort ready", o_req_ready, 1);
    chk("abort busy", o_busy, 0);
    chk("abort coin", o_return_coin, 0);
    chk("abort empty", o_hopper_empty, 3'b000);
    late_pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_return_coin != 3'b000) late_pulses++;
    end
    chk("abort no_more_pulses", late_pulses, 0);
    chk("abort still_idle", o_busy, 0);

    // Hoppers back at INIT: the full 2800 pattern pays again.
    exp_coins = '{4, 4, 2, 1, 1, 1};
    run_req("r2800b", 2800, 0, 3'b000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
